cam_capture_decim: RTL

//  Parametrised successor to the OV7670 byte-pair capture stage: assembles 2-byte pixels from the

---
 rtl/cam_pkg.sv | 19 +
 rtl/cam_pix_format.sv | 23 ++
 rtl/cam_capture_decim.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared encodings for the camera capture/decimation block: pixel formats,
// capture FSM states and the frame buffer depth helper.
package cam_pkg;

    localparam logic [1:0] MODE_RGB565    = 2'd0;
    localparam logic [1:0] MODE_RGB565_SW = 2'd1;
    localparam logic [1:0] MODE_GRAY8     = 2'd2;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_BLANK     = 2'd1,
        ST_ACTIVE    = 2'd2
    } cam_state_e;

    function automatic int calc_depth(input int x_max, input int y_max, input int decim);
        return (x_max / decim) * (y_max / decim);
    endfunction

endpackage

// File: rtl/cam_pix_format.sv
// Packs an assembled hi/lo byte pair into the 16-bit frame buffer word
// according to the mode latched at frame start.
module cam_pix_format
    import cam_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [7:0]  hi,
    input  logic [7:0]  lo,
    output logic [15:0] word
);

    always_comb begin
        word = 16'h0000;
        case (mode)
            MODE_RGB565:    word = {hi, lo};
            MODE_RGB565_SW: word = {lo, hi};
            // YUV422 arrives Y-first, so the hi byte carries luma
            MODE_GRAY8:     word = {8'h00, hi};
            default:        word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/cam_capture_decim.sv
// Camera byte-pair capture with x/y decimation, frame-sync gating and
// overflow / line-error / frame-done reporting into a frame BRAM.
//
// state     | meaning
// WAIT_SYNC | after reset; ignore bus until vsync is seen high
// BLANK     | vsync high; counters, address and overflow cleared
// ACTIVE    | vsync low; bytes captured, kept pixels written
module cam_capture_decim
    import cam_pkg::*;
#(
    parameter int X_MAX  = 640,
    parameter int Y_MAX  = 480,
    parameter int DECIM  = 2,
    parameter int ADDR_W = 17
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              bram_we,
    output logic              frame_done,
    output logic              overflow,
    output logic              line_err
);

    localparam int DEPTH = calc_depth(X_MAX, Y_MAX, DECIM);
    localparam int X_W   = $clog2(X_MAX + 1);
    localparam int Y_W   = $clog2(Y_MAX + 1);

    localparam logic [X_W-1:0]    X_LAST    = X_W'(X_MAX);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(Y_MAX);
    localparam logic [X_W-1:0]    X_MASK    = X_W'(DECIM - 1);
    localparam logic [Y_W-1:0]    Y_MASK    = Y_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    cam_state_e        state_q, state_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [1:0]        mode_q, mode_d;
    logic              href_q, href_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              full_q, full_d;
    logic              wrote_q, wrote_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;
    logic              line_err_q, line_err_d;

    logic [15:0]       pix_word;
    logic              keep;

    cam_pix_format u_fmt (
        .mode (mode_q),
        .hi   (hi_q),
        .lo   (d),
        .word (pix_word)
    );

    // Pixels beyond the active width are never kept, so a long line cannot
    // spill extra words into the next line's addresses.
    assign keep = (x_q != X_LAST) && ((x_q & X_MASK) == '0) && ((y_q & Y_MASK) == '0);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        x_d          = x_q;
        y_d          = y_q;
        mode_d       = mode_q;
        href_d       = 1'b0;
        addr_d       = addr_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        full_d       = full_q;
        wrote_d      = wrote_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        line_err_d   = 1'b0;

        case (state_q)
            ST_WAIT_SYNC: begin
                if (vsync) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                x_d        = '0;
                y_d        = '0;
                addr_d     = '0;
                phase_d    = 1'b0;
                overflow_d = 1'b0;
                full_d     = 1'b0;
                wrote_d    = 1'b0;
                if (!vsync) begin
                    state_d = ST_ACTIVE;
                    mode_d  = mode;
                end
            end
            ST_ACTIVE: begin
                // Address advances after the write it labelled; the last slot is sticky.
                if (we_q) begin
                    if (addr_q == ADDR_LAST) full_d = 1'b1;
                    else                     addr_d = addr_q + 1'b1;
                end
                if (vsync) begin
                    state_d      = ST_BLANK;
                    frame_done_d = wrote_q;
                end else begin
                    href_d = href;
                    if (href) begin
                        phase_d = ~phase_q;
                        if (!phase_q) begin
                            hi_d = d;
                        end else begin
                            if (x_q != X_LAST) x_d = x_q + 1'b1;
                            if (keep) begin
                                if (full_q) begin
                                    overflow_d = 1'b1;
                                end else begin
                                    we_d    = 1'b1;
                                    dout_d  = pix_word;
                                    wrote_d = 1'b1;
                                end
                            end
                        end
                    end else if (href_q) begin
                        if (y_q != Y_LAST) y_d = y_q + 1'b1;
                        x_d        = '0;
                        phase_d    = 1'b0;
                        line_err_d = (x_q != X_LAST) || phase_q;
                    end
                end
            end
            default: state_d = ST_WAIT_SYNC;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT_SYNC;
            phase_q      <= 1'b0;
            hi_q         <= 8'h00;
            x_q          <= '0;
            y_q          <= '0;
            mode_q       <= 2'b00;
            href_q       <= 1'b0;
            addr_q       <= '0;
            dout_q       <= 16'h0000;
            we_q         <= 1'b0;
            full_q       <= 1'b0;
            wrote_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            x_q          <= x_d;
            y_q          <= y_d;
            mode_q       <= mode_d;
            href_q       <= href_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            full_q       <= full_d;
            wrote_q      <= wrote_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            line_err_q   <= line_err_d;
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign bram_we    = we_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign line_err   = line_err_q;

endmodule
